// File: rtl/captura_resta.sv
// Two-operand capture FSM feeding an external ripple subtractor; registers a-b and status.
// Optional flag registers are enabled by defining CAPTURA_RESTA_FLAGS_EN.
module captura_resta #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] sw,
  input  logic         btn_load,
  input  logic         clr,
  output logic [N-1:0] op_a,
  output logic [N-1:0] op_b,
  output logic         cin_o,
  input  logic [N-1:0] diff_i,
  input  logic         cout_i,
  output logic [N-1:0] result,
  output logic         flag_z,
  output logic         flag_n,
  output logic         flag_c,
  output logic         flag_v,
  output logic         done,
  output logic [1:0]   state_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GOT_A = 2'd1,
    CALC  = 2'd2,
    SHOW  = 2'd3
  } state_t;

  state_t       state_reg, state_next;
  logic         btn_q;
  logic         ld;
  logic [N-1:0] op_a_reg, op_a_next;
  logic [N-1:0] op_b_reg, op_b_next;
  logic [N-1:0] result_reg, result_next;
  logic         done_reg, done_next;
  logic         calc_fire;

  // Only the press edge of the already-debounced button acts.
  assign ld = btn_load & ~btn_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      btn_q      <= 1'b0;
      op_a_reg   <= '0;
      op_b_reg   <= '0;
      result_reg <= '0;
      done_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      btn_q      <= btn_load;
      op_a_reg   <= op_a_next;
      op_b_reg   <= op_b_next;
      result_reg <= result_next;
      done_reg   <= done_next;
    end
  end

  // clr overrides everything, so a coincident ld is simply dropped.
  always_comb begin
    state_next  = state_reg;
    op_a_next   = op_a_reg;
    op_b_next   = op_b_reg;
    result_next = result_reg;
    done_next   = done_reg;
    calc_fire   = 1'b0;
    if (clr) begin
      state_next = IDLE;
      done_next  = 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (ld) begin
            op_a_next  = sw;
            state_next = GOT_A;
          end
        end
        GOT_A: begin
          if (ld) begin
            op_b_next  = sw;
            state_next = CALC;
          end
        end
        CALC: begin
          calc_fire   = 1'b1;
          result_next = diff_i;
          done_next   = 1'b1;
          state_next  = SHOW;
        end
        SHOW: begin
          if (ld) begin
            op_a_next  = sw;
            done_next  = 1'b0;
            state_next = GOT_A;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  assign op_a    = op_a_reg;
  assign op_b    = op_b_reg;
  assign cin_o   = 1'b1;
  assign result  = result_reg;
  assign done    = done_reg;
  assign state_o = state_reg;

`ifdef CAPTURA_RESTA_FLAGS_EN
  logic flag_z_reg, flag_n_reg, flag_c_reg, flag_v_reg;

  // Overflow: operands of differing sign and a result whose sign departs from the minuend.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flag_z_reg <= 1'b0;
      flag_n_reg <= 1'b0;
      flag_c_reg <= 1'b0;
      flag_v_reg <= 1'b0;
    end else if (calc_fire) begin
      flag_z_reg <= (diff_i == '0);
      flag_n_reg <= diff_i[N-1];
      flag_c_reg <= cout_i;
      flag_v_reg <= (op_a_reg[N-1] ^ op_b_reg[N-1]) & (op_a_reg[N-1] ^ diff_i[N-1]);
    end
  end

  assign flag_z = flag_z_reg;
  assign flag_n = flag_n_reg;
  assign flag_c = flag_c_reg;
  assign flag_v = flag_v_reg;
`else
  logic flags_unused;

  assign flags_unused = cout_i ^ calc_fire;
  assign flag_z = 1'b0;
  assign flag_n = 1'b0;
  assign flag_c = 1'b0;
  assign flag_v = 1'b0;
`endif

endmodule

// File: doc/captura_resta.md
CAPTURA_RESTA -- requirements
Module: captura_resta

Interface
REQ-001 Parameter N, default 4, operand and result width in bits; the block SHALL support any N >= 2.
REQ-002 clk  input  1  single system clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 sw  input  N  operand value from switches, sampled on a load event.
REQ-005 btn_load  input  1  load button, level (already debounced); only its rising edge acts.
REQ-006 clr  input  1  synchronous clear back to IDLE.
REQ-007 op_a  output  N  minuend driven to the downstream ripple subtractor's a port.
REQ-008 op_b  output  N  subtrahend driven to the subtractor's b port.
REQ-009 cin_o  output  1  subtractor carry-in; SHALL be constant 1, so the subtractor computes a-b.
REQ-010 diff_i  input  N  difference returned combinationally by the subtractor.
REQ-011 cout_i  input  1  subtractor carry-out (1 = no borrow).
REQ-012 result  output  N  registered difference.
REQ-013 flag_z, flag_n, flag_c, flag_v  output  1 each  registered zero, negative, carry and overflow flags.
REQ-014 done  output  1  high while result and flags are valid.
REQ-015 state_o  output  2  current state code, for LEDs.

Function
REQ-016 Edge detect: btn_q SHALL be btn_load registered; ld = btn_load & ~btn_q; a held button SHALL produce exactly one ld.
REQ-017 States SHALL be IDLE=0, GOT_A=1, CALC=2, SHOW=3, and state_o SHALL equal the state code.
REQ-018 IDLE on ld: op_a <= sw, go to GOT_A; otherwise stay.
REQ-019 GOT_A on ld: op_b <= sw, go to CALC; otherwise stay.
REQ-020 CALC: unconditionally go to SHOW after one cycle, and in that cycle register:
- result <= diff_i, flag_c <= cout_i, done <= 1
- flag_z <= (diff_i == 0), flag_n <= diff_i[N-1]
- flag_v <= (op_a[N-1] ^ op_b[N-1]) & (op_a[N-1] ^ diff_i[N-1])
REQ-021 Latency: done SHALL rise on the 2nd rising edge after the ld that loads B.
REQ-022 SHOW: hold result, flags and done; on ld: op_a <= sw, done <= 0, go to GOT_A (op_b, result and flags held).
REQ-023 op_a and op_b SHALL change only on the ld events above and SHALL be stable throughout CALC.
REQ-024 ld in CALC SHALL be ignored.
REQ-025 clr (any state): go to IDLE, done <= 0; operands, result and flags hold.
REQ-026 clr and ld in the same cycle: clr SHALL win and the ld SHALL be discarded.
REQ-027 Arithmetic is modulo 2^N; wrap-around is reported only through flag_c and flag_v, never saturated.

Reset
REQ-028 rst high SHALL immediately force, regardless of clk:
- state = IDLE
- op_a, op_b, result = 0
- all flags, done, btn_q = 0
REQ-029 rst asserted mid-operation SHALL discard captured operands; after release, the first rising edge on btn_load SHALL load A.

Configuration
REQ-030 Macro CAPTURA_RESTA_FLAGS_EN: when defined, the flag registers are implemented per REQ-020.
REQ-031 When CAPTURA_RESTA_FLAGS_EN is undefined, flag_z, flag_n, flag_c and flag_v SHALL be constant 0 with no flag registers; all other behaviour is unchanged.

Verification (N=4, CAPTURA_RESTA_FLAGS_EN defined, bench models the subtractor as a + ~b + 1)
REQ-032 Load A=7 then B=3 -> two cycles later result=4, done=1, Z=0, N=0, C=1, V=0, state_o=3.
REQ-033 A=3, B=7 -> result=12, N=1, C=0, Z=0, V=0.
REQ-034 A=5, B=5 -> result=0, Z=1, C=1; then A=8, B=1 -> result=7, V=1, C=1, N=0.
REQ-035 btn_load held high for 10 cycles in IDLE with sw=6 -> op_a=6 and state_o=1 after exactly one capture; state stays GOT_A.
REQ-036 rst pulsed in GOT_A, or clr and ld together in GOT_A -> state_o=0, done=0; for rst also op_a=0 immediately without a clock edge.
REQ-037 In SHOW, ld with sw=2 -> op_a=2, done=0, state_o=1, result held.
